// File: rtl/adder_seq_chunked_if.sv
// Operand/result handshake bundle for the chunked sequential add/subtract unit.
// master drives operands and out_ready; slave (the arithmetic unit) drives results and in_ready.
interface adder_seq_chunked_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, in1, in2, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, in1, in2, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/adder_seq_chunked.sv
// Multi-cycle add/subtract through one CHUNK-bit ripple slice; result valid WIDTH/CHUNK cycles after accept.
// Result is held in DONE until out_ready; in_ready stays low through RUN and DONE.
module adder_seq_chunked #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input logic                clk,
    input logic                rst_n,
    adder_seq_chunked_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                       state_q;
    logic [NCHUNK-1:0][CHUNK-1:0] a_q;
    logic [NCHUNK-1:0][CHUNK-1:0] b_q;
    logic [NCHUNK-1:0][CHUNK-1:0] sum_q;
    logic                         carry_q;
    logic [IDXW-1:0]              idx_q;
    logic                         out_valid_q;
    logic                         cout_q;
    logic                         ovf_q;

    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK:0]   slice;
    logic             msb_cin;

    // The single ripple slice; carry into the top bit is recovered from the sum bit.
    always_comb begin
        a_c     = a_q[idx_q];
        b_c     = b_q[idx_q];
        slice   = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
        msb_cin = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ slice[CHUNK-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtract is A + ~B + ~borrow, so invert B and the carry-in here.
                        a_q     <= bus.in1;
                        b_q     <= bus.sub ? ~bus.in2 : bus.in2;
                        carry_q <= bus.cin ^ bus.sub;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= slice[CHUNK-1:0];
                    carry_q      <= slice[CHUNK];
                    idx_q        <= idx_q + IDXW'(1);
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= slice[CHUNK];
                        ovf_q       <= msb_cin ^ slice[CHUNK];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_adder_seq_chunked.sv
// Directed bench for adder_seq_chunked: CHUNK=8 main instance plus CHUNK=64 and CHUNK=1 builds.
module tb_adder_seq_chunked;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    adder_seq_chunked_if #(.WIDTH(64)) bus8 ();
    adder_seq_chunked_if #(.WIDTH(64)) bus64 ();
    adder_seq_chunked_if #(.WIDTH(64)) bus1 ();

    adder_seq_chunked #(.WIDTH(64), .CHUNK(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    adder_seq_chunked #(.WIDTH(64), .CHUNK(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));
    adder_seq_chunked #(.WIDTH(64), .CHUNK(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one operation on the CHUNK=8 instance; called at posedge+1.
    task automatic do_op(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic c, input logic s, input logic [63:0] es,
                         input logic ec, input logic eo);
        int lat;
        chk({name, ".in_ready"}, 64'(bus8.in_ready), 64'd1);
        bus8.in1 = a; bus8.in2 = b; bus8.cin = c; bus8.sub = s; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, ".latency"}, 64'(lat), 64'd8);
        chk({name, ".sum"}, bus8.sum, es);
        chk({name, ".cout"}, 64'(bus8.cout), 64'(ec));
        chk({name, ".overflow"}, 64'(bus8.overflow), 64'(eo));
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        chk({name, ".out_valid_drop"}, 64'(bus8.out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat64, lat1, n;
        logic [63:0] held;
        tests = 0;
        fails = 0;
        vecs[0]  = '{"zero",      64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0};
        vecs[1]  = '{"wrap_cin",  64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b1, 1'b0, 64'h1, 1'b1, 1'b0};
        vecs[2]  = '{"pos_ovf",   64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h8000000000000000, 1'b0, 1'b1};
        vecs[3]  = '{"sub_5_3",   64'h5, 64'h3, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
        vecs[4]  = '{"sub_0_1",   64'h0, 64'h1, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
        vecs[5]  = '{"sub_ovf",   64'h8000000000000000, 64'h1, 1'b0, 1'b1, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b1};
        vecs[6]  = '{"chunk_cy",  64'h00000000000000FF, 64'h1, 1'b0, 1'b0, 64'h100, 1'b0, 1'b0};
        vecs[7]  = '{"sub_borrow",64'hA, 64'h3, 1'b1, 1'b1, 64'h6, 1'b1, 1'b0};
        vecs[8]  = '{"neg_ovf",   64'h8000000000000000, 64'h8000000000000000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[9]  = '{"sub_m1_ovf",64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 64'h8000000000000000, 1'b0, 1'b1};
        vecs[10] = '{"mixed",     64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
        vecs[11] = '{"alt_cin",   64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};

        bus8.in_valid = 0;  bus8.in1 = 0;  bus8.in2 = 0;  bus8.cin = 0;  bus8.sub = 0;  bus8.out_ready = 0;
        bus64.in_valid = 0; bus64.in1 = 0; bus64.in2 = 0; bus64.cin = 0; bus64.sub = 0; bus64.out_ready = 0;
        bus1.in_valid = 0;  bus1.in1 = 0;  bus1.in2 = 0;  bus1.cin = 0;  bus1.sub = 0;  bus1.out_ready = 0;

        rst_n = 1'b0;
        #3;
        chk("rst.in_ready", 64'(bus8.in_ready), 64'd1);
        chk("rst.out_valid", 64'(bus8.out_valid), 64'd0);
        chk("rst.sum", bus8.sum, 64'h0);
        chk("rst.cout", 64'(bus8.cout), 64'd0);
        chk("rst.overflow", 64'(bus8.overflow), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Abort at RUN chunk 3: three chunks of AA+55 written, upper chunks still zero.
        bus8.in1 = 64'hAAAAAAAAAAAAAAAA; bus8.in2 = 64'h5555555555555555;
        bus8.cin = 1'b0; bus8.sub = 1'b0; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrun.partial_sum", bus8.sum, 64'h0000000000FFFFFF);
        chk("midrun.in_ready", 64'(bus8.in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midrun.rst_sum", bus8.sum, 64'h0);
        chk("midrun.rst_out_valid", 64'(bus8.out_valid), 64'd0);
        chk("midrun.rst_in_ready", 64'(bus8.in_ready), 64'd1);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus8.out_valid) n++;
            @(posedge clk); #1;
        end
        chk("midrun.no_result", 64'(n), 64'd0);
        do_op("post_rst", 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++)
            do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                  vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);

        // Backpressure: result held in DONE while new operands are offered.
        bus8.in1 = 64'h10; bus8.in2 = 64'h20; bus8.cin = 0; bus8.sub = 0; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        n = 0;
        while (!bus8.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp.latency", 64'(n), 64'd8);
        held = bus8.sum;
        chk("bp.sum", held, 64'h30);
        for (int i = 0; i < 5; i++) begin
            bus8.in_valid = 1'b1;
            bus8.in1 = 64'h1000 + 64'(i);
            @(posedge clk); #1;
            chk("bp.hold_sum", bus8.sum, 64'h30);
            chk("bp.hold_valid", 64'(bus8.out_valid), 64'd1);
            chk("bp.hold_in_ready", 64'(bus8.in_ready), 64'd0);
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        chk("bp.release_in_ready", 64'(bus8.in_ready), 64'd1);
        chk("bp.release_valid", 64'(bus8.out_valid), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("bp.no_capture", 64'(bus8.in_ready), 64'd1);

        // CHUNK=64 and CHUNK=1 builds run the same operation side by side.
        bus64.in1 = 64'hFFFFFFFFFFFFFFFF; bus64.in2 = 64'hFFFFFFFFFFFFFFFF; bus64.in_valid = 1'b1;
        bus1.in1  = 64'hFFFFFFFFFFFFFFFF; bus1.in2  = 64'hFFFFFFFFFFFFFFFF; bus1.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus64.in_valid = 1'b0;
        bus1.in_valid  = 1'b0;
        lat64 = -1;
        lat1  = -1;
        for (int c = 1; c <= 200 && (lat64 < 0 || lat1 < 0); c++) begin
            @(posedge clk); #1;
            if (lat64 < 0 && bus64.out_valid) lat64 = c;
            if (lat1 < 0 && bus1.out_valid) lat1 = c;
        end
        chk("c64.latency", 64'(lat64), 64'd1);
        chk("c64.sum", bus64.sum, 64'hFFFFFFFFFFFFFFFE);
        chk("c64.cout", 64'(bus64.cout), 64'd1);
        chk("c64.overflow", 64'(bus64.overflow), 64'd0);
        chk("c1.latency", 64'(lat1), 64'd64);
        chk("c1.sum", bus1.sum, 64'hFFFFFFFFFFFFFFFE);
        chk("c1.cout", 64'(bus1.cout), 64'd1);
        chk("c1.overflow", 64'(bus1.overflow), 64'd0);
        bus64.out_ready = 1'b1;
        bus1.out_ready  = 1'b1;
        @(posedge clk); #1;
        bus64.out_ready = 1'b0;
        bus1.out_ready  = 1'b0;
        chk("c64.in_ready", 64'(bus64.in_ready), 64'd1);
        chk("c1.in_ready", 64'(bus1.in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adder_seq_chunked.md
# adder_seq_chunked

Parametrised multi-cycle add/subtract unit that processes WIDTH-bit operands CHUNK bits per clock through a single CHUNK-bit ripple-carry slice. It trades latency for area against the fully combinational 64-bit ripple-carry adder. It adds a valid/ready handshake, a subtract mode and signed-overflow reporting. It sits in the adders library as the area-optimised alternative for datapaths that tolerate multi-cycle arithmetic.

## Interface

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK (localparam) = WIDTH/CHUNK.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  unit can accept an operation; equals (state==IDLE).
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- cin  in  1  carry-in for add; borrow-in for subtract.
- sub  in  1  0: A+B+cin; 1: A−B−cin.
- out_valid  out  1  result held on sum/cout/overflow.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  add: carry-out; subtract: 1 = no borrow.
- overflow  out  1  two's-complement signed overflow.

## Operation

- FSM states: IDLE, RUN, DONE.
- **IDLE:** in_ready=1. On in_valid at a clock edge:
  - capture A=in1 and B'=(sub ? ~in2 : in2);
  - set carry=cin^sub and chunk index=0;
  - go to RUN.
- **RUN:** each cycle, slice i computes A[i]+B'[i]+carry.
  - Writes sum[i*CHUNK +: CHUNK] and updates carry.
  - Index increments.
  - At i=NCHUNK−1: register cout=final carry and overflow=carry into MSB XOR carry out of MSB, then go to DONE.
- **DONE:** out_valid=1; sum/cout/overflow stable. When out_ready=1 at an edge, go to IDLE.
- Subtract identity: A−B−cin = A+~B+(1−cin), hence carry-in = cin^sub.
- in_valid outside IDLE is ignored; operands are not re-sampled after capture.
- sum chunks not yet written in RUN hold their previous values. sum is only defined while out_valid=1.
- CHUNK==WIDTH: RUN lasts exactly one cycle.

## Timing

- **Reset** (rst_n low, immediate, no clock needed): state=IDLE, out_valid=0, sum=0, cout=0, overflow=0, carry=0, index=0. in_ready reads 1.
  - No capture while rst_n is low.
  - Release is synchronised by the integrator; the first capture is allowed on the first rising edge with rst_n high.
- **Reset mid-RUN or mid-DONE:** operation aborted, no out_valid, outputs return to reset values.
- **Latency:** operation accepted at edge E0 → RUN on edges E1..E(NCHUNK) → out_valid=1 after edge E(NCHUNK).
- **Minimum issue interval:** NCHUNK+2 cycles (DONE exit edge, then IDLE accept edge). in_ready is low throughout RUN and DONE.
- **Backpressure:** out_valid and results stay constant for any number of cycles with out_ready=0.
- out_ready=1 together with out_valid: transfer completes on that edge; out_valid=0 the next cycle. out_valid is never 0 while state=DONE.

## Test plan

Default WIDTH=64, CHUNK=8 unless noted; check out_valid rises exactly 8 cycles after accept.
- in1=0, in2=0, cin=0, sub=0 → sum=0, cout=0, overflow=0.
- in1=FFFFFFFFFFFFFFFF, in2=1, cin=1, sub=0 → sum=1, cout=1, overflow=0. Then in1=7FFFFFFFFFFFFFFF, in2=1 → sum=8000000000000000, cout=0, overflow=1.
- Subtract, sub=1:
  - in1=5, in2=3, cin=0 → sum=2, cout=1;
  - in1=0, in2=1, cin=0 → sum=FFFFFFFFFFFFFFFF, cout=0, overflow=0;
  - in1=8000000000000000, in2=1 → sum=7FFFFFFFFFFFFFFF, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing in1 → result unchanged, in_ready=0, no new capture. Release out_ready → in_ready=1 one cycle later.
- Reset: assert rst_n=0 at RUN chunk 3 of AAAA…+5555… → out_valid=0, sum=0 immediately. Next operation (AAAAAAAAAAAAAAAA+5555555555555555, cin=1) → sum=0, cout=1.
- CHUNK=64 and CHUNK=1 builds: FFFFFFFFFFFFFFFF+FFFFFFFFFFFFFFFF, cin=0 → sum=FFFFFFFFFFFFFFFE, cout=1, with out_valid after 1 and 64 cycles respectively.
